// File: rtl/lcd_hd44780_responder.sv
// Controller-side model of an HD44780 4-bit LCD bus: decodes nibbles on falling
// LCD_E, executes the instruction subset in use, keeps a readable DDRAM image.
module lcd_hd44780_responder #(
  parameter int FREQ          = 50000000,
  parameter int EXEC_SHORT_US = 37,
  parameter int EXEC_LONG_US  = 1520
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [4:0] LCD_D,
  input  logic       LCD_E,
  input  logic [6:0] rd_addr,
  output logic [7:0] rd_data,
  output logic [6:0] cursor_addr,
  output logic       four_bit_mode,
  output logic       two_line,
  output logic       display_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       entry_inc,
  output logic       entry_shift,
  output logic       busy,
  output logic       cmd_strobe,
  output logic [8:0] last_byte,
  output logic       protocol_error
);

  localparam longint SHORT_CYC = longint'(EXEC_SHORT_US) * longint'(FREQ) / 64'sd1000000;
  localparam longint LONG_CYC  = longint'(EXEC_LONG_US) * longint'(FREQ) / 64'sd1000000;
  localparam int     CNT_W     = ($clog2(LONG_CYC + 64'sd1) > 17) ? $clog2(LONG_CYC + 64'sd1) : 17;
  localparam logic [CNT_W-1:0] SHORT_N = CNT_W'(SHORT_CYC);
  localparam logic [CNT_W-1:0] LONG_N  = CNT_W'(LONG_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  typedef enum logic {PH_HIGH = 1'b0, PH_LOW = 1'b1} phase_t;

  // Address counter step with the two-line DDRAM wrap points (0x27/0x40, 0x67/0x00).
  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
    logic [6:0] r;
    if (inc) begin
      case (ac)
        7'h27:   r = 7'h40;
        7'h67:   r = 7'h00;
        default: r = ac + 7'd1;
      endcase
    end else begin
      case (ac)
        7'h00:   r = 7'h67;
        7'h40:   r = 7'h27;
        default: r = ac - 7'd1;
      endcase
    end
    return r;
  endfunction

  logic [7:0]       mem [0:127];
  logic             e_r, hi_rs_r, cgram_r, sweep_on_r;
  logic [4:0]       d_r;
  logic [3:0]       hi_nib_r;
  logic [6:0]       sweep_addr_r;
  logic [CNT_W-1:0] cnt_r;
  phase_t           phase_r;

  logic             fall_s, exec_s, exec_rs_s, mem_we_s;
  logic [7:0]       exec_byte_s, mem_wdata_s;
  logic [6:0]       mem_addr_s, sweep_addr_s, ac_s;
  logic [3:0]       hi_nib_s;
  logic [CNT_W-1:0] cnt_s;
  logic [8:0]       last_s;
  logic             hi_rs_s, cgram_s, sweep_on_s, four_s, two_s, disp_s, cur_s;
  logic             blink_s, inc_s, shift_s, strobe_s, err_s;
  phase_t           phase_s;

  // Next-state: nibble assembly, instruction execution, busy timer and clear sweep.
  always_comb begin
    fall_s       = e_r & ~LCD_E;
    exec_s       = 1'b0;
    exec_rs_s    = 1'b0;
    exec_byte_s  = 8'h00;
    mem_we_s     = 1'b0;
    mem_addr_s   = 7'h00;
    mem_wdata_s  = 8'h00;
    phase_s      = phase_r;
    hi_nib_s     = hi_nib_r;
    hi_rs_s      = hi_rs_r;
    cgram_s      = cgram_r;
    sweep_on_s   = sweep_on_r;
    sweep_addr_s = sweep_addr_r;
    ac_s         = cursor_addr;
    four_s       = four_bit_mode;
    two_s        = two_line;
    disp_s       = display_on;
    cur_s        = cursor_on;
    blink_s      = blink_on;
    inc_s        = entry_inc;
    shift_s      = entry_shift;
    strobe_s     = 1'b0;
    last_s       = last_byte;
    err_s        = protocol_error;
    cnt_s        = (cnt_r != CNT_ZERO) ? (cnt_r - CNT_ONE) : CNT_ZERO;

    if (sweep_on_r) begin
      mem_we_s     = 1'b1;
      mem_addr_s   = sweep_addr_r;
      mem_wdata_s  = 8'h20;
      sweep_addr_s = sweep_addr_r + 7'd1;
      sweep_on_s   = (sweep_addr_r != 7'h7F);
    end else begin
      sweep_addr_s = sweep_addr_r;
    end

    if (fall_s) begin
      if (busy) begin
        err_s = 1'b1;
      end else if (!four_bit_mode) begin
        exec_s      = 1'b1;
        exec_rs_s   = d_r[4];
        exec_byte_s = {d_r[3:0], 4'h0};
      end else if (phase_r == PH_HIGH) begin
        hi_nib_s = d_r[3:0];
        hi_rs_s  = d_r[4];
        phase_s  = PH_LOW;
      end else begin
        exec_s      = 1'b1;
        exec_rs_s   = hi_rs_r;
        exec_byte_s = {hi_nib_r, d_r[3:0]};
        phase_s     = PH_HIGH;
        err_s       = protocol_error | (d_r[4] != hi_rs_r);
      end
    end else begin
      exec_s = 1'b0;
    end

    if (exec_s) begin
      strobe_s = 1'b1;
      last_s   = {exec_rs_s, exec_byte_s};
      cnt_s    = SHORT_N;
      if (exec_rs_s) begin
        // CGRAM writes are not modelled; only the address counter moves.
        if (!cgram_r) begin
          mem_we_s    = 1'b1;
          mem_addr_s  = cursor_addr;
          mem_wdata_s = exec_byte_s;
        end else begin
          mem_we_s = 1'b0;
        end
        ac_s = ac_step(cursor_addr, entry_inc);
      end else begin
        casez (exec_byte_s)
          8'b1???????: begin ac_s = exec_byte_s[6:0]; cgram_s = 1'b0; end
          8'b01??????: cgram_s = 1'b1;
          8'b001?????: begin
            four_s = ~exec_byte_s[4];
            two_s  = exec_byte_s[3];
            if (!exec_byte_s[4]) begin
              phase_s = PH_HIGH;
            end else begin
              phase_s = phase_r;
            end
          end
          8'b0001????: begin
            if (!exec_byte_s[3]) begin
              ac_s = ac_step(cursor_addr, exec_byte_s[2]);
            end else begin
              ac_s = cursor_addr;
            end
          end
          8'b00001???: begin
            disp_s  = exec_byte_s[2];
            cur_s   = exec_byte_s[1];
            blink_s = exec_byte_s[0];
          end
          8'b000001??: begin inc_s = exec_byte_s[1]; shift_s = exec_byte_s[0]; end
          8'b0000001?: begin ac_s = 7'h00; cnt_s = LONG_N; end
          8'b00000001: begin
            ac_s         = 7'h00;
            inc_s        = 1'b1;
            cnt_s        = LONG_N;
            sweep_on_s   = 1'b1;
            sweep_addr_s = 7'h00;
          end
          default: cnt_s = SHORT_N;
        endcase
      end
    end else begin
      strobe_s = 1'b0;
    end
  end

  // State register; reset starts an implicit clear sweep under a long busy window.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      e_r            <= 1'b0;
      d_r            <= 5'h00;
      phase_r        <= PH_HIGH;
      hi_nib_r       <= 4'h0;
      hi_rs_r        <= 1'b0;
      cgram_r        <= 1'b0;
      sweep_on_r     <= 1'b1;
      sweep_addr_r   <= 7'h00;
      cnt_r          <= LONG_N;
      busy           <= 1'b1;
      cursor_addr    <= 7'h00;
      four_bit_mode  <= 1'b0;
      two_line       <= 1'b0;
      display_on     <= 1'b0;
      cursor_on      <= 1'b0;
      blink_on       <= 1'b0;
      entry_inc      <= 1'b1;
      entry_shift    <= 1'b0;
      cmd_strobe     <= 1'b0;
      last_byte      <= 9'h000;
      protocol_error <= 1'b0;
    end else begin
      e_r            <= LCD_E;
      d_r            <= LCD_E ? LCD_D : d_r;
      phase_r        <= phase_s;
      hi_nib_r       <= hi_nib_s;
      hi_rs_r        <= hi_rs_s;
      cgram_r        <= cgram_s;
      sweep_on_r     <= sweep_on_s;
      sweep_addr_r   <= sweep_addr_s;
      cnt_r          <= cnt_s;
      busy           <= (cnt_s != CNT_ZERO);
      cursor_addr    <= ac_s;
      four_bit_mode  <= four_s;
      two_line       <= two_s;
      display_on     <= disp_s;
      cursor_on      <= cur_s;
      blink_on       <= blink_s;
      entry_inc      <= inc_s;
      entry_shift    <= shift_s;
      cmd_strobe     <= strobe_s;
      last_byte      <= last_s;
      protocol_error <= err_s;
    end
  end

  // DDRAM write port (sweep or data write).
  always_ff @(posedge CLK) begin
    if (RST_N && mem_we_s) begin
      mem[mem_addr_s] <= mem_wdata_s;
    end
  end

  // Registered read-back port.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rd_data <= 8'h00;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: doc/lcd_hd44780_responder.md
# lcd_hd44780_responder

Synthesizable model of the HD44780-compatible controller end of the 4-bit LCD bus that our LCD init/text controller drives through `LCD_D`/`LCD_E`. It decodes the nibble stream on falling `LCD_E` edges and tracks the 4-bit entry handshake. It executes the instruction set subset we use and keeps a 128-byte DDRAM image that a bench or on-chip checker can read back. It also enforces execution-time rules by flagging any transfer issued while busy.

## Interface
- `FREQ`, 50000000: clock frequency in Hz.
- `EXEC_SHORT_US`, 37: execution time of every instruction except clear and home, and of every data write.
- `EXEC_LONG_US`, 1520: execution time of clear display and return home.
- `CLK`  in  1  system clock; all logic on rising edge.
- `RST_N`  in  1  synchronous, active-low reset.
- `LCD_D`  in  5  bit 4 = RS, bits 3:0 = DB7..DB4.
- `LCD_E`  in  1  enable strobe; data latched on its falling edge.
- `rd_addr`  in  7  DDRAM read-back address.
- `rd_data`  out  8  DDRAM[rd_addr], registered.
- `cursor_addr`  out  7  current address counter (AC).
- `four_bit_mode`  out  1  interface is in 4-bit nibble-pair mode.
- `two_line`, `display_on`, `cursor_on`, `blink_on`, `entry_inc`, `entry_shift`  out  1 each  mode bits as last programmed.
- `busy`  out  1  instruction executing.
- `cmd_strobe`  out  1  one-cycle pulse per executed byte.
- `last_byte`  out  9  {RS, byte} of the last executed transfer.
- `protocol_error`  out  1  sticky error flag, cleared only by reset.

## Operation
- Edge detect: `e_q` registers `LCD_E`. While `LCD_E`=1, `d_q` captures `LCD_D`. A fall is `e_q & ~LCD_E` and uses `d_q`.
- 8-bit mode (after reset): each fall forms byte {d_q[3:0], 4'b0000} with RS=d_q[4] and executes it immediately.
- Function set with DL=0 in 8-bit mode (byte 0x2X) sets `four_bit_mode`, nibble phase = high.
- 4-bit mode: the first fall supplies the high nibble and RS. The second fall supplies the low nibble, and the byte executes. If RS differs between the two nibbles, set `protocol_error`; the high-nibble RS wins.
- Function set with DL=1 returns the block to 8-bit mode.
- Instruction decode (RS=0, highest set bit wins):
  - 0x01 clear: AC=0, `entry_inc`=1, fill all 128 DDRAM bytes with 0x20, one per cycle during busy.
  - 0x02/0x03 home: AC=0.
  - 0x04–07 entry mode: I/D=bit1, S=bit0.
  - 0x08–0F display control: D=bit2, C=bit1, B=bit0.
  - 0x10–1F cursor/display shift: if bit3=0, AC ±1 (bit2=1 → +1) with the wrap rules below; display shift is a no-op.
  - 0x20–3F function set: DL=bit4, N=bit3 → `two_line`; F is ignored.
  - 0x40–7F set CGRAM address: enter CGRAM mode; subsequent data writes are discarded, but AC still steps.
  - 0x80–FF set DDRAM address: AC=byte[6:0]; leave CGRAM mode.
- Data write (RS=1): DDRAM[AC]=byte, then AC steps per `entry_inc`.
- AC wrap rules:
  - Increment: 0x27→0x40, 0x67→0x00.
  - Decrement: 0x00→0x67, 0x40→0x27.
  - Any other out-of-range address steps plainly modulo 128.
- Busy: after every executed byte, `busy` holds for EXEC_SHORT_US×FREQ/1e6 cycles (EXEC_LONG for clear/home). The counter is 17 bits minimum.
- In 8-bit mode every fall is a byte and starts busy. In 4-bit mode the high-nibble fall does not start busy.
- Any `LCD_E` fall while `busy`=1: set `protocol_error`, drop the nibble, leave the nibble phase unchanged.

## Timing
- Reset values:
  - `entry_inc`=1; all other mode bits, `four_bit_mode`, `cmd_strobe`, `last_byte`, `protocol_error` and `cursor_addr` = 0.
  - Nibble phase = high.
  - `busy`=1 for EXEC_LONG while an implicit clear sweep runs, so DDRAM = 0x20 after reset.
- Byte execution: the fall is detected in cycle T. Register updates, `cmd_strobe`, `last_byte` and `busy` rise take effect at T+1.
- A busy window of N cycles ends with `busy`=0 at T+1+N. A fall detected at T+1+N is accepted.
- Clear sweep writes addresses 0..127 over cycles T+1..T+128. It has priority over nothing else because no data write can start while busy.
- `rd_data` latency is 1 cycle. A read during a sweep or write returns the old contents.
- Reset asserted mid-pair or mid-busy aborts everything and restarts from the reset values.

## Test plan
- Reset, then read addresses 0x00, 0x27, 0x40, 0x7F → all 0x20; `busy` falls exactly EXEC_LONG cycles after reset release.
- Init sequence of nibbles 3,3,3,2 then bytes 0x28,0x08,0x01,0x06,0x0C with the host's 4.1ms/100µs/53µs/3ms gaps → `four_bit_mode`=1, `two_line`=1, `display_on`=1, `cursor_on`=0, `entry_inc`=1, `protocol_error`=0.
- Write "AB" (RS=1 bytes 0x41,0x42), then 0xC0, then 0x43 → DDRAM[0x00]=0x41, DDRAM[0x01]=0x42, DDRAM[0x40]=0x43; final `cursor_addr`=0x41.
- AC=0x27 then data write → `cursor_addr`=0x40. Set entry mode 0x04, AC=0x00, write → `cursor_addr`=0x67.
- Issue the second nibble of a byte 10 cycles after a 0x01 completes → `protocol_error`=1, nibble dropped, DDRAM unchanged.
- RS=1 high nibble followed by RS=0 low nibble of 0x48 → `protocol_error`=1, byte executed as data 0x48.
